// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Ports: CLK/RST, IF lookup (if_pc -> bp_stat, pred_taken, pred_npc, btb_hit),
// MEM training (upd_*), saturating branch / mispredict counters.
package dp_types_pkg;
  typedef enum logic [1:0] {
    BPRED_NS = 2'b00,
    BPRED_NH = 2'b01,
    BPRED_TH = 2'b10,
    BPRED_TS = 2'b11
  } bpred_t;
endpackage

module branch_predictor
  import dp_types_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic [1:0]  bp_stat,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  output logic        btb_hit,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [31:0]     tgt_q   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];

  logic [31:0] br_q, br_d;
  logic [31:0] mp_q, mp_d;

  logic [IDX-1:0]  lidx;
  logic [TAGW-1:0] ltag;
  logic            lhit;
  logic [31:0]     seq_npc;

  assign lidx = if_pc[IDX+1:2];
  assign ltag = if_pc[31:IDX+2];
  assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);
  // Low PC bits never carry into bit 2, so masking after the add aligns.
  assign seq_npc = (if_pc + 32'd4) & 32'hFFFF_FFFC;

  always_comb begin
    btb_hit    = lhit;
    bp_stat    = BPRED_NH;
    pred_taken = 1'b0;
    pred_npc   = seq_npc;
    if (lhit) begin
      bp_stat    = ctr_q[lidx];
      pred_taken = ctr_q[lidx][1];
      pred_npc   = ctr_q[lidx][1] ? tgt_q[lidx] : seq_npc;
    end
  end

  logic [IDX-1:0]  uidx;
  logic [TAGW-1:0] utag;
  logic            uhit;
  logic            wr_en;
  logic [1:0]      ctr_d;
  logic [31:0]     tgt_d;
  logic            unused_lsb;

  assign uidx       = upd_pc[IDX+1:2];
  assign utag       = upd_pc[31:IDX+2];
  assign uhit       = valid_q[uidx] && (tag_q[uidx] == utag);
  assign unused_lsb = ^upd_pc[1:0];

  always_comb begin
    wr_en = 1'b0;
    ctr_d = ctr_q[uidx];
    tgt_d = tgt_q[uidx];
    if (upd_en) begin
      unique case (1'b1)
        uhit && upd_taken: begin
          wr_en = 1'b1;
          ctr_d = (ctr_q[uidx] == BPRED_TS) ? BPRED_TS
                                            : ctr_q[uidx] + 2'd1;
          tgt_d = upd_target;
        end
        uhit && !upd_taken: begin
          wr_en = 1'b1;
          ctr_d = (ctr_q[uidx] == BPRED_NS) ? BPRED_NS
                                            : ctr_q[uidx] - 2'd1;
        end
        !uhit && upd_taken: begin
          // Allocation evicts whatever aliased entry lives here.
          wr_en = 1'b1;
          ctr_d = BPRED_TH;
          tgt_d = upd_target;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_en) begin
      if (br_q != 32'hFFFF_FFFF) br_d = br_q + 32'd1;
      if (upd_mispred && mp_q != 32'hFFFF_FFFF) mp_d = mp_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= BPRED_NH;
      end
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[uidx] <= 1'b1;
        ctr_q[uidx]   <= ctr_d;
      end
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  // Tags and targets need no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      tag_q[uidx] <= utag;
      tgt_q[uidx] <= tgt_d;
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Scoreboard of expected lookups, counters tracked alongside stimulus.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] if_pc;
  logic [1:0]  bp_stat;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        btb_hit;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST),
    .if_pc(if_pc), .bp_stat(bp_stat),
    .pred_taken(pred_taken), .pred_npc(pred_npc),
    .btb_hit(btb_hit),
    .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic        hit;
    logic [1:0]  stat;
    logic        tkn;
    logic [31:0] npc;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] br_exp  = 0;
  logic [31:0] mp_exp  = 0;

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", t, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".hit"},  {31'd0, btb_hit},    {31'd0, e.hit});
    chk({e.tag, ".stat"}, {30'd0, bp_stat},    {30'd0, e.stat});
    chk({e.tag, ".tkn"},  {31'd0, pred_taken}, {31'd0, e.tkn});
    chk({e.tag, ".npc"},  pred_npc,            e.npc);
    chk({e.tag, ".br"},   br_count,            e.br);
    chk({e.tag, ".mp"},   mispred_count,       e.mp);
  endtask

  task automatic look(input string t, input logic [31:0] pc,
                      input logic h, input logic [1:0] st,
                      input logic [31:0] npc);
    @(negedge CLK);
    if_pc = pc;
    sb_q.push_back('{t, h, st, h & st[1], npc, br_exp, mp_exp});
    #2;
    compare_head();
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic mp);
    @(negedge CLK);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk;
    upd_target = tg; upd_mispred = mp;
    @(posedge CLK);
    #1 upd_en = 1'b0;
    if (br_exp != 32'hFFFF_FFFF) br_exp++;
    if (mp && mp_exp != 32'hFFFF_FFFF) mp_exp++;
  endtask

  initial begin
    RST = 1'b1; if_pc = 0; upd_en = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; upd_mispred = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    look("reset", 32'h40, 1'b0, 2'b01, 32'h44);

    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("alloc", 32'h40, 1'b1, 2'b10, 32'h100);

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("tk1", 32'h40, 1'b1, 2'b11, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("tk_sat", 32'h40, 1'b1, 2'b11, 32'h100);

    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look("nt1", 32'h40, 1'b1, 2'b10, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("nt2", 32'h40, 1'b1, 2'b01, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("nt_sat", 32'h40, 1'b1, 2'b00, 32'h44);

    upd(32'h80, 1'b1, 32'h200, 1'b1);
    look("alias_old", 32'h40, 1'b0, 2'b01, 32'h44);
    look("alias_new", 32'h80, 1'b1, 2'b10, 32'h200);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("alias_keep", 32'h80, 1'b1, 2'b10, 32'h200);
    look("misalign_hit", 32'h83, 1'b1, 2'b10, 32'h200);
    look("misalign_miss", 32'h46, 1'b0, 2'b01, 32'h48);

    // Lookup and update of the same entry in one cycle.
    @(negedge CLK);
    if_pc = 32'h80;
    upd_en = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
    upd_target = 32'h300; upd_mispred = 1'b0;
    sb_q.push_back('{"same_old", 1'b1, 2'b10, 1'b1, 32'h200,
                     br_exp, mp_exp});
    #2 compare_head();
    @(posedge CLK);
    #1 upd_en = 1'b0;
    br_exp++;
    look("same_new", 32'h80, 1'b1, 2'b11, 32'h300);

    // Idle update inputs with upd_en low must not train.
    @(negedge CLK);
    upd_pc = 32'h140; upd_taken = 1'b1;
    upd_target = 32'h500; upd_mispred = 1'b1;
    look("idle", 32'h140, 1'b0, 2'b01, 32'h144);

    // Reset beats a concurrent update.
    @(negedge CLK);
    RST = 1'b1;
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h400; upd_mispred = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0; upd_en = 1'b0;
    br_exp = 0; mp_exp = 0;
    look("rst_upd", 32'h100, 1'b0, 2'b01, 32'h104);
    look("rst_clr", 32'h80, 1'b0, 2'b01, 32'h84);

    // Counter saturation.
    @(negedge CLK);
    force dut.br_q = 32'hFFFF_FFFE;
    force dut.mp_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_q;
    release dut.mp_q;
    br_exp = 32'hFFFF_FFFE; mp_exp = 32'hFFFF_FFFE;
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("sat1", 32'h40, 1'b1, 2'b10, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("sat2", 32'h40, 1'b1, 2'b11, 32'h100);
    chk("sat_br", br_count, 32'hFFFF_FFFF);
    chk("sat_mp", mispred_count, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits in the IF stage, directly upstream of the hazard unit. Produces the prediction state (bp_stat) and the predicted next PC that travel down the pipeline with each instruction.
- Is trained from the MEM stage with the resolved branch outcome, the same point where the hazard unit declares a misprediction.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX = log2(ENTRIES).
- TAGW, 30-IDX, tag width. Derived; not overridable.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- if_pc  in  32  PC of the instruction in IF (word aligned).
- bp_stat  out  2  counter state for if_pc: BPRED_NS=00, BPRED_NH=01, BPRED_TH=10, BPRED_TS=11 (dp_types_pkg).
- pred_taken  out  1  predicted taken.
- pred_npc  out  32  predicted next PC.
- btb_hit  out  1  if_pc matched a valid entry.
- upd_en  in  1  a resolved conditional branch (BEQ/BNE) is in MEM this cycle.
- upd_pc  in  32  PC of that branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  branch target address.
- upd_mispred  in  1  hazard unit reported ~phit for this branch.
- br_count  out  32  resolved-branch count.
- mispred_count  out  32  mispredict count.

Behaviour:
- Index is pc[IDX+1:2]. Tag is pc[31:IDX+2].
- Per-entry storage: valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational, with zero latency from if_pc.
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - On hit: bp_stat=ctr; pred_taken=ctr[1]; pred_npc = pred_taken ? target : if_pc+4.
  - On miss: bp_stat=BPRED_NH, pred_taken=0, pred_npc=if_pc+4, btb_hit=0.
- Update is registered and takes effect at the CLK edge when upd_en=1.
  - Hit on upd_pc:
    - Taken: ctr NS→NH→TH→TS→TS.
    - Not taken: TS→TH→NH→NS→NS.
    - Taken: target := upd_target. Not taken: target is unchanged.
  - Miss on upd_pc:
    - Taken: allocate. Set valid=1, tag, target=upd_target, ctr=BPRED_TH. Any existing entry at that index is replaced.
    - Not taken: no change.
- upd_en=0: table is unchanged. upd_taken, upd_target, upd_mispred are ignored.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. There is no write-to-read bypass, and the new value is visible from the next cycle.
- Statistics, on each edge with upd_en=1:
  - br_count += 1, saturating at 32'hFFFFFFFF.
  - mispred_count += upd_mispred, also saturating.
- Reset, on an edge with RST=1:
  - All valid=0 and all ctr=BPRED_NH. Tags and targets are don't-care.
  - br_count=0, mispred_count=0.
  - RST has priority over a concurrent upd_en; that update is discarded.
  - Combinational outputs reflect an empty table from the cycle after reset.
- Aliasing: two PCs with the same index and different tags thrash the entry. Each taken update replaces the entry; a not-taken update to a non-matching tag leaves it intact.
- if_pc or upd_pc with nonzero bits [1:0]: those bits are ignored.

Test Plan (ENTRIES=16):
- Reset, then if_pc=0x0000_0040 → btb_hit=0, bp_stat=01, pred_taken=0, pred_npc=0x44; br_count=0, mispred_count=0.
- upd_en, upd_pc=0x40, taken, target=0x100, mispred=1 → next cycle if_pc=0x40: hit, bp_stat=10, pred_npc=0x100; br_count=1, mispred_count=1.
- Three more taken updates on 0x40 → ctr sticks at 11. Then two not-taken updates → ctr 10 then 01; pred_npc=0x44 after the second.
- Alias: 0x40 allocated, then taken update of 0x80 (same index 0, different tag), target 0x200 → lookup of 0x40 misses, lookup of 0x80 hits with 0x200. A not-taken update of 0x40 then leaves the 0x80 entry intact.
- if_pc=0x40 while upd_en updates 0x40 in the same cycle → outputs show old ctr that cycle and new ctr the next cycle.
- RST asserted with upd_en=1 on the same edge → table empty and counters 0; the update is lost. Separately, with br_count forced near 32'hFFFFFFFF, further updates hold it at 32'hFFFFFFFF.
